config_bitstream_receiver: RTL

- Receiving end of the serial configuration protocol driven by CGRA_configurator.
- Accepts one bit per valid cycle, first-sent bit first, and assembles them in a shadow shift register.
- When exactly TOTAL_NUM_BITS bits have arrived, it atomically commits the shadow into the active configuration word that feeds the fabric's ConstVal/Mux/Func config fields.
- Detects short and overrun streams and provides a scan output for chaining receivers.

---
 rtl/config_bitstream_receiver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/config_bitstream_receiver.sv
// Serial configuration receiver: shifts bits into a shadow register and commits
// the full stream atomically to config_out, flagging short and overrun streams.
module config_bitstream_receiver #(
    parameter int unsigned TOTAL_NUM_BITS = 465,
    parameter int unsigned COUNT_WIDTH    = $clog2(TOTAL_NUM_BITS + 1)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      sync_reset,
    input  logic                      bitstream_in,
    input  logic                      bitstream_valid,
    input  logic                      done_in,
    output logic [TOTAL_NUM_BITS-1:0] config_out,
    output logic                      config_valid,
    output logic                      busy,
    output logic                      error,
    output logic                      scan_out,
    output logic [COUNT_WIDTH-1:0]    bit_count
);

    localparam int unsigned N = TOTAL_NUM_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOADING   = 2'd1;
    localparam logic [1:0] S_COMMITTED = 2'd2;
    localparam logic [1:0] S_ERROR     = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(N - 1);

    logic [1:0]             state, state_nxt;
    logic [N-1:0]           shadow, shadow_nxt, shifted;
    logic [N-1:0]           config_nxt;
    logic                   config_valid_nxt;
    logic                   busy_nxt;
    logic                   error_nxt;
    logic                   scan_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;

    assign shifted = {shadow[N-2:0], bitstream_in};

    // Next-state and next-output decode
    always_comb begin
        state_nxt        = state;
        shadow_nxt       = shadow;
        config_nxt       = config_out;
        config_valid_nxt = config_valid;
        error_nxt        = error;
        count_nxt        = bit_count;

        if (sync_reset) begin
            state_nxt        = S_IDLE;
            shadow_nxt       = '0;
            count_nxt        = '0;
            error_nxt        = 1'b0;
            config_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bitstream_valid) begin
                        shadow_nxt = shifted;
                        count_nxt  = COUNT_WIDTH'(1);
                        state_nxt  = S_LOADING;
                    end
                end
                S_LOADING: begin
                    if (bitstream_valid) begin
                        shadow_nxt = shifted;
                        count_nxt  = bit_count + COUNT_WIDTH'(1);
                        if (bit_count == LAST_CNT) begin
                            config_nxt       = shifted;
                            config_valid_nxt = 1'b1;
                            state_nxt        = S_COMMITTED;
                        end else if (done_in) begin
                            error_nxt = 1'b1;
                            state_nxt = S_ERROR;
                        end
                    end else if (done_in) begin
                        error_nxt = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
                S_COMMITTED: begin
                    // An extra bit after a full stream is an overrun; the bit is dropped
                    if (bitstream_valid) begin
                        error_nxt = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
                S_ERROR: begin
                    state_nxt = S_ERROR;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == S_LOADING);
        scan_nxt = shadow_nxt[N-1];
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            shadow       <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            scan_out     <= 1'b0;
            bit_count    <= '0;
        end else begin
            state        <= state_nxt;
            shadow       <= shadow_nxt;
            config_out   <= config_nxt;
            config_valid <= config_valid_nxt;
            busy         <= busy_nxt;
            error        <= error_nxt;
            scan_out     <= scan_nxt;
            bit_count    <= count_nxt;
        end
    end

endmodule
